sopc_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the SOPC data bus, alongside `data_ram`. It is driven by the same CPU RAM port signals: `ram_ce_o`, `ram_we_o`, `ram_addr_o`, `ram_sel_o` and `ram_data_o`. Stored bytes are buffered in a small FIFO and serialised as 8N1 frames on `txd`. The top level ORs `data_o` into the CPU read-data path, gated by its own address decode.

---
 rtl/sopc_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_sopc_uart_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sopc_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register map (addr[3:2]): 0 TXDATA, 1 STATUS, 2 CTRL, 3 reserved.
module sopc_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        txd,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   baud, baud_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [7:0]      shift, shift_n;
    logic            txd_n;
    logic            pop;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic            full, empty, busy;
    logic            ovf, tx_en, irq_en;

    // Bus decode; only byte lane 0 carries write data
    logic       hit, wr, rd_hit;
    logic [1:0] rsel;
    logic       push, ovf_set;
    assign hit     = ce && (addr[31:4] == BASE_ADDR[31:4]);
    assign rsel    = addr[3:2];
    assign wr      = hit && we && sel[0];
    assign rd_hit  = hit && !we;

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign busy    = (state != IDLE) || !empty;
    // Push is judged against the pre-pop occupancy: a full FIFO refuses even while draining
    assign push    = wr && (rsel == 2'd0) && !full;
    assign ovf_set = wr && (rsel == 2'd0) && full;
    assign irq     = irq_en && empty && (state == IDLE);

    logic unused;
    assign unused = &{1'b0, addr[1:0], sel[3:1], data_i[31:8], data_i[2]};

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= data_i[7:0];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    // Control/status registers; a same-cycle overflow beats a software clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf    <= 1'b0;
            tx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else begin
            if (ovf_set)                             ovf <= 1'b1;
            else if (wr && rsel == 2'd1 && data_i[3]) ovf <= 1'b0;
            if (wr && rsel == 2'd2) begin
                tx_en  <= data_i[0];
                irq_en <= data_i[1];
            end
        end
    end

    // Zero-latency register read-back
    always_comb begin
        data_o = '0;
        if (rd_hit) begin
            case (rsel)
                2'd1:    data_o = {28'd0, ovf, busy, empty, full};
                2'd2:    data_o = {30'd0, irq_en, tx_en};
                default: data_o = '0;
            endcase
        end
    end

    // TX FSM state and datapath registers; txd is registered from its next value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            baud   <= '0;
            bitcnt <= '0;
            shift  <= '0;
            txd    <= 1'b1;
        end else begin
            state  <= state_n;
            baud   <= baud_n;
            bitcnt <= bitcnt_n;
            shift  <= shift_n;
            txd    <= txd_n;
        end
    end

    // TX FSM next-state: each bit lasts CLK_DIV cycles, frames chain without an idle gap
    always_comb begin
        state_n  = state;
        baud_n   = baud;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        txd_n    = txd;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (tx_en && !empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rptr];
                    state_n = START;
                    baud_n  = BAUD_MAX;
                    txd_n   = 1'b0;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_n  = DATA;
                    baud_n   = BAUD_MAX;
                    bitcnt_n = '0;
                    txd_n    = shift[0];
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_n = BAUD_MAX;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bitcnt_n = bitcnt + 3'd1;
                        shift_n  = {1'b0, shift[7:1]};
                        txd_n    = shift[1];
                    end
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            STOP: begin
                if (baud == '0) begin
                    if (tx_en && !empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rptr];
                        state_n = START;
                        baud_n  = BAUD_MAX;
                        txd_n   = 1'b0;
                    end else begin
                        state_n = IDLE;
                        txd_n   = 1'b1;
                    end
                end else begin
                    baud_n = baud - BW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sopc_uart_tx.sv
// Scoreboarded bench: bytes queued on TXDATA writes, popped by a serial receiver.
module tb_sopc_uart_tx;
    localparam int          DIV  = 4;
    localparam int          FLEN = 10 * DIV;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;
    localparam logic [31:0] A_RS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, data_i = '0;
    logic [3:0]  sel = '0;
    logic [31:0] data_o;
    logic        txd, irq;

    int checks = 0, errors = 0;
    int cyc = 0;
    int nframes = 0, ndone = 0;
    int start_cyc [0:31];
    bit mon_en = 1'b1;
    logic [7:0] exp_q [$];
    int last_wr_cyc;

    sopc_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
        .data_i(data_i), .data_o(data_o), .txd(txd), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b1; addr = a; data_i = d; sel = s;
        @(posedge clk); #1;
        last_wr_cyc = cyc;
        ce = 1'b0; we = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        ce = 1'b1; we = 1'b0; addr = a;
        #2 d = data_o;
        ce = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (ndone < n && k < budget) begin @(posedge clk); k++; end
        chk("frames_done", ndone, n);
    endtask

    task automatic wait_start(input int n, input int budget);
        int k = 0;
        while (nframes < n && k < budget) begin @(posedge clk); k++; end
        chk("frames_started", nframes, n);
    endtask

    task automatic quiet_chk(input string tag, input int ncyc);
        int lows = 0;
        repeat (ncyc) begin @(negedge clk); if (txd !== 1'b1) lows++; end
        chk(tag, lows, 0);
    endtask

    // Serial receiver: checks every cycle of a frame against the expected bit pattern
    initial begin : rx_mon
        logic [7:0] rb, eb;
        logic       xb;
        int         errs;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (mon_en && rst && txd === 1'b0) begin
                if (nframes < 32) start_cyc[nframes] = cyc;
                nframes++;
                chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                eb = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                rb = '0; errs = 0; aborted = 1'b0;
                for (int n = 0; n < FLEN; n++) begin
                    if (n > 0) @(negedge clk);
                    if (!rst) begin aborted = 1'b1; break; end
                    xb = (n < DIV) ? 1'b0 : (n >= 9*DIV) ? 1'b1 : eb[(n-DIV)/DIV];
                    if (txd !== xb) errs++;
                    if (n >= DIV && n < 9*DIV && (n % DIV) == DIV/2) rb[(n-DIV)/DIV] = txd;
                end
                if (!aborted) begin
                    chk("rx_byte", rb, eb);
                    chk("frame_shape", errs, 0);
                    ndone++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : main
        int base, ce_wr;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1);
        chk("rst_irq", irq, 0);
        rst = 1'b1;
        rd_chk("rst_status", A_ST, 32'h2);
        rd_chk("rst_ctrl", A_CT, 32'h1);
        rd_chk("txdata_reads_0", A_TX, 32'h0);
        rd_chk("rsvd_reads_0", A_RS, 32'h0);

        // Single byte: start bit at E+1, BUSY set with FIFO already drained
        exp_q.push_back(8'h55);
        bus_wr(A_TX, 32'h55, 4'hF);
        ce_wr = last_wr_cyc;
        rd_chk("busy_mid_frame", A_ST, 32'h6);
        wait_done(1, 100);
        chk("start_latency", start_cyc[0], ce_wr + 1);
        rd_chk("status_after_frame", A_ST, 32'h2);

        // Overflow with TX disabled; BUSY also reflects a non-empty FIFO
        bus_wr(A_CT, 32'h0, 4'hF);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) exp_q.push_back(8'(i * 37 + 3));
            bus_wr(A_TX, 32'(i * 37 + 3), 4'hF);
        end
        rd_chk("status_full_ovf", A_ST, 32'hD);
        bus_wr(A_ST, 32'h8, 4'hF);
        rd_chk("status_ovf_clr", A_ST, 32'h5);

        // Burst, halted during frame 3
        base = nframes;
        bus_wr(A_CT, 32'h1, 4'hF);
        wait_start(base + 3, 200);
        bus_wr(A_CT, 32'h0, 4'hF);
        wait_done(base + 3, 200);
        quiet_chk("halt_txd_idle", 60);
        chk("halt_frames", nframes, base + 3);
        chk("gap_1_2", start_cyc[base+1] - start_cyc[base], FLEN);
        chk("gap_2_3", start_cyc[base+2] - start_cyc[base+1], FLEN);
        rd_chk("status_halted", A_ST, 32'h4);

        // Resume the remaining five back to back
        bus_wr(A_CT, 32'h1, 4'hF);
        wait_done(base + 8, 400);
        for (int i = 3; i < 7; i++)
            chk("gap_resume", start_cyc[base+i+1] - start_cyc[base+i], FLEN);
        rd_chk("status_drained", A_ST, 32'h2);

        // Decode misses and disabled byte lane must not push
        bus_wr(BASE + 32'h10, 32'h77, 4'hF);
        bus_wr(A_TX, 32'h66, 4'b1110);
        rd_chk("status_no_push", A_ST, 32'h2);
        rd_chk("miss_reads_0", BASE + 32'h18, 32'h0);
        quiet_chk("no_stray_frame", 50);

        // IRQ
        bus_wr(A_CT, 32'h3, 4'hF);
        @(negedge clk);
        chk("irq_set", irq, 1);
        exp_q.push_back(8'hA5);
        bus_wr(A_TX, 32'hA5, 4'hF);
        chk("irq_clr_on_push", irq, 0);
        wait_done(ndone + 1, 100);
        @(posedge clk); #1;
        chk("irq_after_frame", irq, 1);

        // Async reset mid-DATA: byte is discarded, so not queued
        mon_en = 1'b0;
        bus_wr(A_TX, 32'h3C, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset_data_low", txd, 0);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_txd", txd, 1);
        chk("async_rst_irq", irq, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        rd_chk("post_rst_status", A_ST, 32'h2);
        rd_chk("post_rst_ctrl", A_CT, 32'h1);
        quiet_chk("no_resume", 60);
        mon_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
